// File: rtl/fpu_pipe_unit.sv
// rtl/fpu_pipe_unit.sv - handshaked single-precision FPU: stage-1 operand register feeding a tagged result FIFO.
// Arithmetic truncates, flushes subnormals to zero, and saturates to infinity on overflow.
module fpu_adder_top (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] result,
    output logic        error,
    output logic        overflow,
    output logic        underflow
);
    logic              sa, sb, sl, swap, found;
    logic [7:0]        ea, eb, el, d;
    logic [23:0]       ma, mb, ml, ms, norm;
    logic [24:0]       sum;
    logic [4:0]        sh;
    logic signed [9:0] e;
    logic [22:0]       mant;

    always_comb begin
        sa = a[31];
        sb = b[31] ^ sub;
        ea = a[30:23];
        eb = b[30:23];
        ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
        mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
        swap = b[30:0] > a[30:0];
        el = swap ? eb : ea;
        sl = swap ? sb : sa;
        ml = swap ? mb : ma;
        d  = el - (swap ? ea : eb);
        ms = (d > 8'd24) ? 24'd0 : ((swap ? ma : mb) >> d);
        sum = (sa == sb) ? ({1'b0, ml} + {1'b0, ms}) : ({1'b0, ml} - {1'b0, ms});
        sh = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && sum[i]) begin
                sh = 5'(23 - i);
                found = 1'b1;
            end
        end
        norm = sum[23:0] << sh;
        if (sum[24]) begin
            e = $signed({2'b00, el}) + 10'sd1;
            mant = sum[23:1];
        end else begin
            e = $signed({2'b00, el}) - $signed({5'b00000, sh});
            mant = norm[22:0];
        end
        result = 32'd0;
        error = 1'b0;
        overflow = 1'b0;
        underflow = 1'b0;
        if ((ea == 8'hFF && a[22:0] != 23'd0) || (eb == 8'hFF && b[22:0] != 23'd0)) begin
            error = 1'b1;
            result = 32'h7FC0_0000;
        end else if (ea == 8'hFF && eb == 8'hFF && sa != sb) begin
            error = 1'b1;
            result = 32'h7FC0_0000;
        end else if (ea == 8'hFF) begin
            result = {sa, 8'hFF, 23'd0};
        end else if (eb == 8'hFF) begin
            result = {sb, 8'hFF, 23'd0};
        end else if (sum == 25'd0) begin
            result = 32'd0;
        end else if (e >= 10'sd255) begin
            overflow = 1'b1;
            result = {sl, 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            underflow = 1'b1;
            result = {sl, 31'd0};
        end else begin
            result = {sl, e[7:0], mant};
        end
    end
endmodule

module float_multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        error,
    output logic        overflow,
    output logic        underflow
);
    logic              s, za, zb, ia, ib, na, nb;
    logic [47:0]       prod;
    logic signed [9:0] e;
    logic [22:0]       mant;

    always_comb begin
        s  = a[31] ^ b[31];
        za = a[30:23] == 8'd0;
        zb = b[30:23] == 8'd0;
        ia = a[30:23] == 8'hFF && a[22:0] == 23'd0;
        ib = b[30:23] == 8'hFF && b[22:0] == 23'd0;
        na = a[30:23] == 8'hFF && a[22:0] != 23'd0;
        nb = b[30:23] == 8'hFF && b[22:0] != 23'd0;
        prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (prod[47]) begin
            e = e + 10'sd1;
            mant = prod[46:24];
        end else begin
            mant = prod[45:23];
        end
        result = 32'd0;
        error = 1'b0;
        overflow = 1'b0;
        underflow = 1'b0;
        if (na || nb || (ia && zb) || (ib && za)) begin
            error = 1'b1;
            result = 32'h7FC0_0000;
        end else if (ia || ib) begin
            result = {s, 8'hFF, 23'd0};
        end else if (za || zb) begin
            result = {s, 31'd0};
        end else if (e >= 10'sd255) begin
            overflow = 1'b1;
            result = {s, 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            underflow = 1'b1;
            result = {s, 31'd0};
        end else begin
            result = {s, e[7:0], mant};
        end
    end
endmodule

module float_divider (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        error,
    output logic        overflow,
    output logic        underflow
);
    logic              s, za, zb, ia, ib, na, nb;
    logic [47:0]       q;
    logic signed [9:0] e;
    logic [22:0]       mant;

    always_comb begin
        s  = a[31] ^ b[31];
        za = a[30:23] == 8'd0;
        zb = b[30:23] == 8'd0;
        ia = a[30:23] == 8'hFF && a[22:0] == 23'd0;
        ib = b[30:23] == 8'hFF && b[22:0] == 23'd0;
        na = a[30:23] == 8'hFF && a[22:0] != 23'd0;
        nb = b[30:23] == 8'hFF && b[22:0] != 23'd0;
        // Quotient of two 1.x mantissas lands in bit 24 or bit 23.
        q = zb ? 48'd0 : ({1'b1, a[22:0], 24'd0} / {24'd0, 1'b1, b[22:0]});
        e = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd126;
        if (q[24]) begin
            e = e + 10'sd1;
            mant = q[23:1];
        end else begin
            mant = q[22:0];
        end
        result = 32'd0;
        error = 1'b0;
        overflow = 1'b0;
        underflow = 1'b0;
        if (na || nb || (ia && ib) || (za && zb)) begin
            error = 1'b1;
            result = 32'h7FC0_0000;
        end else if (zb) begin
            error = 1'b1;
            result = {s, 8'hFF, 23'd0};
        end else if (ia) begin
            result = {s, 8'hFF, 23'd0};
        end else if (ib || za) begin
            result = {s, 31'd0};
        end else if (e >= 10'sd255) begin
            overflow = 1'b1;
            result = {s, 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            underflow = 1'b1;
            result = {s, 31'd0};
        end else begin
            result = {s, e[7:0], mant};
        end
    end
endmodule

module fpu_pipe_unit #(
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_error,
    output logic             out_overflow,
    output logic             out_underflow,
    input  logic             flags_clr,
    output logic             sticky_err,
    output logic             sticky_ovf,
    output logic             sticky_udf,
    output logic             busy
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [31:0]      s1_a, s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [31:0]      add_res, mul_res, div_res, sel_res;
    logic [2:0]       add_flg, mul_flg, div_flg, sel_flg;
    logic [31:0]      mem_res [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic [2:0]       mem_flg [DEPTH];
    logic             accept, pop;

    fpu_adder_top u_add (.a(s1_a), .b(s1_b), .sub(s1_op[0]), .result(add_res),
                         .error(add_flg[2]), .overflow(add_flg[1]), .underflow(add_flg[0]));
    float_multiplier u_mul (.a(s1_a), .b(s1_b), .result(mul_res),
                            .error(mul_flg[2]), .overflow(mul_flg[1]), .underflow(mul_flg[0]));
    float_divider u_div (.a(s1_a), .b(s1_b), .result(div_res),
                         .error(div_flg[2]), .overflow(div_flg[1]), .underflow(div_flg[0]));

    always_comb begin
        sel_res = add_res;
        sel_flg = add_flg;
        if (s1_op == 2'b10) begin
            sel_res = mul_res;
            sel_flg = mul_flg;
        end else if (s1_op == 2'b11) begin
            sel_res = div_res;
            sel_flg = div_flg;
        end
    end

    // Counting the stage-1 entry reserves its FIFO slot, so stage 1 never has to stall.
    assign in_ready  = (count + {{PTR_W{1'b0}}, s1_valid}) < (PTR_W + 1)'(DEPTH);
    assign accept    = in_valid && in_ready;
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign busy      = s1_valid || out_valid;

    assign out_result    = mem_res[rd_ptr];
    assign out_tag       = mem_tag[rd_ptr];
    assign out_error     = mem_flg[rd_ptr][2];
    assign out_overflow  = mem_flg[rd_ptr][1];
    assign out_underflow = mem_flg[rd_ptr][0];

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op  <= in_op;
            s1_a   <= in_a;
            s1_b   <= in_b;
            s1_tag <= in_tag;
        end
        if (s1_valid) begin
            mem_res[wr_ptr] <= sel_res;
            mem_tag[wr_ptr] <= s1_tag;
            mem_flg[wr_ptr] <= sel_flg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            sticky_err <= 1'b0;
            sticky_ovf <= 1'b0;
            sticky_udf <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (s1_valid) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (s1_valid && !pop) count <= count + 1'b1;
            else if (!s1_valid && pop) count <= count - 1'b1;
            if (pop) begin
                sticky_err <= (sticky_err && !flags_clr) || out_error;
                sticky_ovf <= (sticky_ovf && !flags_clr) || out_overflow;
                sticky_udf <= (sticky_udf && !flags_clr) || out_underflow;
            end else if (flags_clr) begin
                sticky_err <= 1'b0;
                sticky_ovf <= 1'b0;
                sticky_udf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fpu_pipe_unit.sv
// tb/tb_fpu_pipe_unit.sv - scoreboard bench for fpu_pipe_unit.
module tb_fpu_pipe_unit;
    localparam int TAG_W = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n, in_valid, in_ready, out_valid, out_ready, flags_clr;
    logic [1:0]       in_op;
    logic [31:0]      in_a, in_b, out_result;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic             out_error, out_overflow, out_underflow;
    logic             sticky_err, sticky_ovf, sticky_udf, busy;

    int               n_checks = 0;
    int               n_fails = 0;
    int               cyc = 0;
    int               last_pop = 0;
    int               prev_pop = 0;
    int               accepted;
    logic [38:0]      sb[$];
    logic [38:0]      exp_e;

    fpu_pipe_unit #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_error(out_error), .out_overflow(out_overflow),
        .out_underflow(out_underflow), .flags_clr(flags_clr), .sticky_err(sticky_err),
        .sticky_ovf(sticky_ovf), .sticky_udf(sticky_udf), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", 64'(out_tag), 64'hFFFF);
            end else begin
                exp_e = sb.pop_front();
                check("pop", 64'({out_tag, out_error, out_overflow, out_underflow, out_result}),
                      64'(exp_e));
            end
            prev_pop = last_pop;
            last_pop = cyc;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input logic [31:0] res,
                         input logic [2:0] flg);
        int n = 0;
        logic done = 1'b0;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_tag = tag;
        while (!done && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({tag, flg, res});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) check("issue_timeout", 64'(n), 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("drain_timeout", 64'(n), 64'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("valid_timeout", 64'(n), 64'd0);
    endtask

    task automatic basic_add();
        out_ready = 1'b0;
        issue(2'b00, 32'h3F80_0000, 32'h4000_0000, 4'd3, 32'h4040_0000, 3'b000);
        @(negedge clk);
        check("latency_n", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("latency_n1", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_op = 2'b00;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        out_ready = 1'b0;
        flags_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_sticky", 64'({sticky_err, sticky_ovf, sticky_udf}), 64'd0);
        @(posedge clk);
        #1;

        basic_add();

        // back-to-back mul then div with the consumer always ready
        out_ready = 1'b1;
        issue(2'b10, 32'h4040_0000, 32'h4000_0000, 4'd5, 32'h40C0_0000, 3'b000);
        issue(2'b11, 32'h40C0_0000, 32'h4000_0000, 4'd9, 32'h4040_0000, 3'b000);
        drain();
        check("b2b_spacing", 64'(last_pop - prev_pop), 64'd1);
        issue(2'b01, 32'h4040_0000, 32'h3F80_0000, 4'd2, 32'h4000_0000, 3'b000);
        drain();

        // fill with consumer stalled
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            in_valid = 1'b1;
            in_op = 2'b00;
            in_a = 32'h3F80_0000;
            in_b = 32'h3F80_0000;
            in_tag = TAG_W'(i);
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({TAG_W'(i), 3'b000, 32'h4000_0000});
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("full_accepted", 64'(accepted), 64'(DEPTH));
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_after_pop", 64'(in_ready), 64'd1);
        drain();

        // divide by zero and sticky error behaviour
        issue(2'b11, 32'h3F80_0000, 32'h0000_0000, 4'd7, 32'h7F80_0000, 3'b100);
        drain();
        check("sticky_err_set", 64'(sticky_err), 64'd1);
        flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
        check("sticky_err_clr", 64'(sticky_err), 64'd0);
        out_ready = 1'b0;
        issue(2'b11, 32'h3F80_0000, 32'h0000_0000, 4'd8, 32'h7F80_0000, 3'b100);
        wait_valid();
        out_ready = 1'b1;
        flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
        check("set_wins", 64'(sticky_err), 64'd1);
        drain();
        flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;

        // overflow / underflow
        issue(2'b10, 32'h7F00_0000, 32'h7F00_0000, 4'd10, 32'h7F80_0000, 3'b010);
        issue(2'b10, 32'h0080_0000, 32'h0080_0000, 4'd11, 32'h0000_0000, 3'b001);
        drain();
        check("sticky_ovf_udf", 64'({sticky_err, sticky_ovf, sticky_udf}), 64'b011);

        // reset with results queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            issue(2'b00, 32'h3F80_0000, 32'h3F80_0000, TAG_W'(12 + i), 32'h4000_0000, 3'b000);
        @(posedge clk);
        #1;
        check("queued_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_busy", 64'(busy), 64'd0);
        check("rst2_in_ready", 64'(in_ready), 64'd1);
        check("rst2_sticky", 64'({sticky_err, sticky_ovf, sticky_udf}), 64'd0);
        basic_add();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
